// File: rtl/idma_desc64_pkg.sv
// Shared types and constants for the desc64 descriptor writer: flag layout,
// beat offsets, request/descriptor structs and the writer FSM states.
package idma_desc64_pkg;

    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Bit positions inside the 32-bit desc64 flags field
    localparam int unsigned FLAG_IRQ         = 0;
    localparam int unsigned FLAG_SRC_BURST   = 1;
    localparam int unsigned FLAG_DST_BURST   = 3;
    localparam int unsigned FLAG_DECOUPLE_RW = 5;
    localparam int unsigned FLAG_DECOUPLE_AW = 6;
    localparam int unsigned FLAG_REDUCE_LEN  = 7;
    localparam int unsigned FLAG_SRC_CACHE   = 8;
    localparam int unsigned FLAG_DST_CACHE   = 12;
    localparam int unsigned FLAG_AXI_ID      = 16;

    localparam logic [4:0] OFFSET_WORD0 = 5'd0;
    localparam logic [4:0] OFFSET_NEXT  = 5'd8;
    localparam logic [4:0] OFFSET_SRC   = 5'd16;
    localparam logic [4:0] OFFSET_DST   = 5'd24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_RSP,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [1:0] burst;
        logic [3:0] cache;
        logic       lock;
        logic [2:0] prot;
        logic [3:0] qos;
    } axi_opt_t;

    typedef struct packed {
        logic       decouple_aw;
        logic       decouple_rw;
        logic       src_reduce_len;
        logic       dst_reduce_len;
        logic [2:0] src_max_llen;
        logic [2:0] dst_max_llen;
    } backend_opt_t;

    typedef struct packed {
        logic [7:0]   axi_id;
        axi_opt_t     src;
        axi_opt_t     dst;
        backend_opt_t beo;
        logic         last;
    } opt_t;

    typedef struct packed {
        addr_t length;
        addr_t src_addr;
        addr_t dst_addr;
        opt_t  opt;
    } idma_req_t;

    // First member is most significant, so length lands in bits [31:0]
    typedef struct packed {
        addr_t       dest_addr;
        addr_t       src_addr;
        addr_t       next;
        logic [31:0] flags;
        logic [31:0] length;
    } descriptor_t;

    typedef data_t [3:0] desc_words_t;

    // Publish-last order: the word holding length/flags is written after the rest
    function automatic logic [4:0] beat_offset(input logic [1:0] beat);
        logic [4:0] offset;
        offset = OFFSET_WORD0;
        case (beat)
            2'd0:    offset = OFFSET_NEXT;
            2'd1:    offset = OFFSET_SRC;
            2'd2:    offset = OFFSET_DST;
            default: offset = OFFSET_WORD0;
        endcase
        return offset;
    endfunction

endpackage

// File: rtl/idma_desc64_packer.sv
// Combinational encoder: backend request + next pointer + irq -> desc64 image,
// with a flag for lengths that do not fit the 32-bit length field.
module idma_desc64_packer
    import idma_desc64_pkg::*;
(
    input  idma_req_t   idma_req_i,
    input  addr_t       next_i,
    input  logic        irq_i,
    output descriptor_t desc_o,
    output logic        overflow_o
);

    // Options with no home in the desc64 format are intentionally discarded
    logic unused_opt_fields;
    assign unused_opt_fields = ^{idma_req_i.opt.src.lock, idma_req_i.opt.src.prot,
                                 idma_req_i.opt.src.qos, idma_req_i.opt.dst.lock,
                                 idma_req_i.opt.dst.prot, idma_req_i.opt.dst.qos,
                                 idma_req_i.opt.beo.src_max_llen,
                                 idma_req_i.opt.beo.dst_max_llen, idma_req_i.opt.last};

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a bit unassigned (no latch).
        desc_o                              = '0;
        desc_o.length                       = idma_req_i.length[31:0];
        desc_o.next                         = next_i;
        desc_o.src_addr                     = idma_req_i.src_addr;
        desc_o.dest_addr                    = idma_req_i.dst_addr;
        desc_o.flags[FLAG_IRQ]              = irq_i;
        desc_o.flags[FLAG_SRC_BURST +: 2]   = idma_req_i.opt.src.burst;
        desc_o.flags[FLAG_DST_BURST +: 2]   = idma_req_i.opt.dst.burst;
        desc_o.flags[FLAG_DECOUPLE_RW]      = idma_req_i.opt.beo.decouple_rw;
        desc_o.flags[FLAG_DECOUPLE_AW]      = idma_req_i.opt.beo.decouple_aw;
        desc_o.flags[FLAG_REDUCE_LEN]       = idma_req_i.opt.beo.src_reduce_len
                                            | idma_req_i.opt.beo.dst_reduce_len;
        desc_o.flags[FLAG_SRC_CACHE +: 4]   = idma_req_i.opt.src.cache;
        desc_o.flags[FLAG_DST_CACHE +: 4]   = idma_req_i.opt.dst.cache;
        desc_o.flags[FLAG_AXI_ID +: 8]      = idma_req_i.opt.axi_id;
    end

    assign overflow_o = |idma_req_i.length[ADDR_WIDTH-1:32];

endmodule

// File: rtl/idma_desc64_writer.sv
// Writes one desc64 descriptor as four 64-bit beats over a req/gnt/rsp bus
// and reports completion, with any bus or encoding error, as a single pulse.
module idma_desc64_writer
    import idma_desc64_pkg::*;
#(
    parameter int unsigned AddrWidth = ADDR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  idma_req_t            idma_req_i,
    input  logic [AddrWidth-1:0] next_i,
    input  logic                 irq_i,
    input  logic [AddrWidth-1:0] desc_addr_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [63:0]          mem_wdata_o,
    output logic [7:0]           mem_strb_o,
    input  logic                 mem_rsp_valid_i,
    input  logic                 mem_rsp_error_i,
    output logic                 done_o,
    output logic                 error_o
);

    state_e                state_q, state_d;
    descriptor_t           desc_packed, desc_q;
    desc_words_t           desc_words;
    logic                  overflow;
    logic [AddrWidth-6:0]  base_q;
    logic [1:0]            beat_q;
    logic [2:0]            rsp_cnt_q, rsp_cnt_nxt, issued;
    logic                  err_q;
    logic                  accept, beat_gnt, last_beat, rsp_accept;
    logic [4:0]            offset;

    idma_desc64_packer i_packer (
        .idma_req_i (idma_req_i),
        .next_i     (next_i),
        .irq_i      (irq_i),
        .desc_o     (desc_packed),
        .overflow_o (overflow)
    );

    assign accept    = req_valid_i && req_ready_o;
    assign beat_gnt  = (state_q == ST_WRITE) && mem_gnt_i;
    assign last_beat = beat_gnt && (beat_q == 2'd3);

    // Beats granted so far, including one granted this very cycle
    always_comb begin
        issued = 3'd0;
        case (state_q)
            ST_WRITE:    issued = {1'b0, beat_q} + {2'b00, beat_gnt};
            ST_WAIT_RSP: issued = 3'd4;
            default:     issued = 3'd0;
        endcase
    end

    assign rsp_accept  = mem_rsp_valid_i && (rsp_cnt_q < issued);
    assign rsp_cnt_nxt = rsp_cnt_q + {2'b00, rsp_accept};

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = ST_WRITE;
            ST_WRITE:    if (last_beat) state_d = (rsp_cnt_nxt == 3'd4) ? ST_DONE : ST_WAIT_RSP;
            ST_WAIT_RSP: if (rsp_cnt_nxt == 3'd4) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the descriptor register is plain flops, not a RAM, so clearing it on reset is cheap and deterministic.
            desc_q    <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                desc_q    <= desc_packed;
                base_q    <= desc_addr_i[AddrWidth-1:5];
                beat_q    <= '0;
                rsp_cnt_q <= '0;
                err_q     <= overflow || (desc_addr_i[4:0] != 5'd0);
            end
            if (beat_gnt) beat_q <= beat_q + 2'd1;
            if (rsp_accept) begin
                rsp_cnt_q <= rsp_cnt_nxt;
                if (mem_rsp_error_i) err_q <= 1'b1;
            end
            if (state_q == ST_DONE) begin
                beat_q    <= '0;
                rsp_cnt_q <= '0;
                err_q     <= 1'b0;
            end
        end
    end

    assign desc_words = desc_q;
    assign offset     = beat_offset(beat_q);

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        mem_req_o   = (state_q == ST_WRITE);
        mem_we_o    = (state_q == ST_WRITE);
        mem_strb_o  = 8'hFF;
        mem_addr_o  = {base_q, offset};
        mem_wdata_o = desc_words[offset[4:3]];
        done_o      = (state_q == ST_DONE);
        error_o     = (state_q == ST_DONE) && err_q;
    end

    // Responses with nothing outstanding are dropped; flag them in simulation
    rsp_without_beat: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rsp_valid_i |-> rsp_accept);

endmodule

// File: tb/tb_idma_desc64_writer.sv
// Directed bench for idma_desc64_writer: a bus slave with optional grant
// backpressure and delayed responses, plus hand-computed descriptor images.
module tb_idma_desc64_writer;
    import idma_desc64_pkg::*;

    localparam int TIMEOUT = 300;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    idma_req_t   idma_req_i;
    logic [63:0] next_i;
    logic        irq_i;
    logic [63:0] desc_addr_i;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [63:0] mem_addr_o;
    logic        mem_we_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_strb_o;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_error_i;
    logic        done_o;
    logic        error_o;

    int n_checks = 0;
    int n_errors = 0;

    // Slave configuration and observation log
    bit          bp_en    = 1'b0;
    bit          rsp_rand = 1'b0;
    int          err_idx  = 0;
    int          slv_wait = 0;
    int          rsp_seen = 0;
    int          tick     = 0;
    int          rsp_due[$];
    logic [63:0] log_addr[$];
    logic [63:0] log_data[$];
    bit          hold_valid = 1'b0;
    logic [63:0] hold_addr, hold_data;

    idma_desc64_writer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .idma_req_i      (idma_req_i),
        .next_i          (next_i),
        .irq_i           (irq_i),
        .desc_addr_i     (desc_addr_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_strb_o      (mem_strb_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_error_i (mem_rsp_error_i),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus slave: decides grant/response at the falling edge for the next rising edge
    initial begin
        mem_gnt_i       = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_error_i = 1'b0;
        forever begin
            @(negedge clk_i);
            mem_gnt_i       = 1'b0;
            mem_rsp_valid_i = 1'b0;
            mem_rsp_error_i = 1'b0;
            if (rst_i === 1'b1) begin
                rsp_due.delete();
                hold_valid = 1'b0;
                slv_wait   = 0;
            end else begin
                if (hold_valid) begin
                    check("hold_req", mem_req_o, 1);
                    check("hold_addr", mem_addr_o, hold_addr);
                    check("hold_data", mem_wdata_o, hold_data);
                end
                hold_valid = 1'b0;
                if (mem_req_o) begin
                    if (slv_wait == 0) begin
                        mem_gnt_i = 1'b1;
                        check("beat_we", mem_we_o, 1);
                        check("beat_strb", mem_strb_o, 8'hFF);
                        log_addr.push_back(mem_addr_o);
                        log_data.push_back(mem_wdata_o);
                        rsp_due.push_back(tick + (rsp_rand ? int'($urandom_range(3, 0)) : 0));
                        slv_wait = bp_en ? int'($urandom_range(5, 0)) : 0;
                    end else begin
                        slv_wait--;
                        hold_valid = 1'b1;
                        hold_addr  = mem_addr_o;
                        hold_data  = mem_wdata_o;
                    end
                end
                if (rsp_due.size() > 0 && rsp_due[0] <= tick) begin
                    void'(rsp_due.pop_front());
                    rsp_seen++;
                    mem_rsp_valid_i = 1'b1;
                    mem_rsp_error_i = (rsp_seen == err_idx);
                end
            end
            tick++;
        end
    end

    // One descriptor write; beat data expectations are next/src/dst and a hand-made word0
    task automatic run_case(input string tag, input idma_req_t req, input logic [63:0] nxt,
                            input logic irq, input logic [63:0] daddr, input logic [63:0] exp_base,
                            input logic [63:0] exp_w0, input logic exp_err, input bit chk_lat);
        int          k;
        bit          seen;
        logic [63:0] exp_addr[4];
        logic [63:0] exp_data[4];
        exp_addr = '{exp_base + 64'd8, exp_base + 64'd16, exp_base + 64'd24, exp_base};
        exp_data = '{nxt, req.src_addr, req.dst_addr, exp_w0};
        log_addr.delete();
        log_data.delete();
        rsp_seen = 0;
        slv_wait = bp_en ? int'($urandom_range(5, 0)) : 0;
        @(negedge clk_i);
        check({tag, "_ready_idle"}, req_ready_o, 1);
        idma_req_i  = req;
        next_i      = nxt;
        irq_i       = irq;
        desc_addr_i = daddr;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k    = 1;
        seen = 1'b0;
        while (k < TIMEOUT) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
            k++;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (chk_lat) check({tag, "_done_cycle"}, k, 5);
        check({tag, "_error"}, error_o, exp_err);
        check({tag, "_rsp_before_done"}, rsp_seen, 4);
        check({tag, "_beats"}, log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_addr[i]);
                check($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
            end
        end
        @(negedge clk_i);
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_ready_back"}, req_ready_o, 1);
    endtask

    idma_req_t   v1, v2, v3;
    logic [63:0] w0;
    logic [31:0] flags;
    int          k;
    int          done_hits;

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        idma_req_i  = '0;
        next_i      = '0;
        irq_i       = 1'b0;
        desc_addr_i = '0;

        // Vector 1: INCR bursts on both sides, axi_id 0x5A, irq set
        v1                  = '0;
        v1.length           = 64'h100;
        v1.src_addr         = 64'h1000;
        v1.dst_addr         = 64'h2000;
        v1.opt.src.burst    = 2'b01;
        v1.opt.dst.burst    = 2'b01;
        v1.opt.axi_id       = 8'h5A;

        // Vector 2: every encoded option nonzero somewhere, dropped fields also set
        v2                        = '0;
        v2.length                 = 64'h40;
        v2.src_addr               = 64'hA000_0000_0000_1230;
        v2.dst_addr               = 64'h0000_0001_2345_6780;
        v2.opt.src.burst          = 2'b10;
        v2.opt.dst.burst          = 2'b00;
        v2.opt.src.cache          = 4'h3;
        v2.opt.dst.cache          = 4'hC;
        v2.opt.beo.decouple_rw    = 1'b1;
        v2.opt.beo.dst_reduce_len = 1'b1;
        v2.opt.axi_id             = 8'hA5;
        v2.opt.src.lock           = 1'b1;
        v2.opt.src.prot           = 3'b101;
        v2.opt.dst.qos            = 4'hF;
        v2.opt.beo.src_max_llen   = 3'd7;
        v2.opt.last               = 1'b1;

        // Vector 3: length does not fit in 32 bits
        v3               = '0;
        v3.length        = 64'h1_0000_0010;
        v3.src_addr      = 64'h4000;
        v3.dst_addr      = 64'h5000;
        v3.opt.src.burst = 2'b01;
        v3.opt.dst.burst = 2'b01;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", req_ready_o, 1);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        rst_i = 1'b0;

        // flags = 1 | 01<<1 | 01<<3 | 0x5A<<16 = 0x005A000B
        run_case("zero_wait", v1, 64'h3000, 1'b1, 64'h8000, 64'h8000,
                 64'h005A_000B_0000_0100, 1'b0, 1'b1);

        // flags = 10<<1 | 1<<5 | 1<<7 | 3<<8 | C<<12 | A5<<16 = 0x00A5C3A4
        bp_en    = 1'b1;
        rsp_rand = 1'b1;
        run_case("bp_v2", v2, 64'hD000, 1'b0, 64'h1_0020, 64'h1_0020,
                 64'h00A5_C3A4_0000_0040, 1'b0, 1'b0);
        if (log_data.size() == 4) begin
            w0    = log_data[3];
            flags = w0[63:32];
            check("rt_length", w0[31:0], v2.length[31:0]);
            check("rt_irq", flags[0], 0);
            check("rt_src_burst", flags[2:1], v2.opt.src.burst);
            check("rt_dst_burst", flags[4:3], v2.opt.dst.burst);
            check("rt_decouple_rw", flags[5], v2.opt.beo.decouple_rw);
            check("rt_decouple_aw", flags[6], v2.opt.beo.decouple_aw);
            check("rt_reduce_len", flags[7],
                  v2.opt.beo.src_reduce_len | v2.opt.beo.dst_reduce_len);
            check("rt_src_cache", flags[11:8], v2.opt.src.cache);
            check("rt_dst_cache", flags[15:12], v2.opt.dst.cache);
            check("rt_axi_id", flags[23:16], v2.opt.axi_id);
            check("rt_reserved", flags[31:24], 0);
            check("rt_next", log_data[0], 64'hD000);
            check("rt_src", log_data[1], v2.src_addr);
            check("rt_dst", log_data[2], v2.dst_addr);
        end
        run_case("bp_v1", v1, 64'h3000, 1'b1, 64'hC000, 64'hC000,
                 64'h005A_000B_0000_0100, 1'b0, 1'b0);
        bp_en    = 1'b0;
        rsp_rand = 1'b0;

        err_idx = 2;
        run_case("rsp_err", v1, 64'h3000, 1'b1, 64'hA000, 64'hA000,
                 64'h005A_000B_0000_0100, 1'b1, 1'b1);
        err_idx = 0;
        run_case("after_err", v1, 64'h3000, 1'b1, 64'hB000, 64'hB000,
                 64'h005A_000B_0000_0100, 1'b0, 1'b1);

        // flags = 01<<1 | 01<<3 = 0x0A; length field keeps only the low 32 bits
        run_case("overflow", v3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h9000, 64'h9000,
                 64'h0000_000A_0000_0010, 1'b1, 1'b1);

        run_case("misalign", v1, 64'h3000, 1'b1, 64'h8004, 64'h8000,
                 64'h005A_000B_0000_0100, 1'b1, 1'b1);

        // Reset after the second grant, then a clean transfer
        log_addr.delete();
        log_data.delete();
        rsp_seen = 0;
        slv_wait = 0;
        @(negedge clk_i);
        idma_req_i  = v1;
        next_i      = 64'h3000;
        irq_i       = 1'b1;
        desc_addr_i = 64'h8000;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        k = 0;
        while (log_addr.size() < 2 && k < TIMEOUT) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check("rst_mid_two_grants", log_addr.size(), 2);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_mid_mem_req", mem_req_o, 0);
        check("rst_mid_done", done_o, 0);
        check("rst_mid_ready", req_ready_o, 1);
        check("rst_mid_beats", log_addr.size(), 2);
        @(negedge clk_i);
        rst_i     = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (done_o) done_hits++;
        end
        check("rst_mid_no_done", done_hits, 0);
        run_case("post_rst", v1, 64'h3000, 1'b1, 64'h8000, 64'h8000,
                 64'h005A_000B_0000_0100, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
